// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester arbiter in front of one shared combinational ALU.
//            Define ALU_ARB_RR_EN for round-robin; otherwise requester 0 has
//            fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_func,
    input  logic [15:0] req0_op1,
    input  logic [15:0] req0_op2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_func,
    input  logic [15:0] req1_op1,
    input  logic [15:0] req1_op2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_data,
    output logic [1:0]  alu_func,
    output logic [15:0] alu_op1,
    output logic [15:0] alu_op2,
    input  logic [15:0] alu_result,
    input  logic        alu_eq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] c_FUNC_EQ = 2'b11;

    logic [1:0]  r_state;
    logic [1:0]  r_func;
    logic [15:0] r_op1;
    logic [15:0] r_op2;
    logic [15:0] r_result;
    logic        r_win;

    logic        w_win;
    logic        w_grant;
    logic        w_rsp_ready;

`ifdef ALU_ARB_RR_EN
    // Pointer holds the index granted last; it loses the next tie.
    logic r_last;

    always_comb begin
        if (req0_valid && req1_valid) begin
            w_win = ~r_last;
        end else begin
            w_win = ~req0_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`else
    assign w_win = ~req0_valid;
`endif

    // Gating with rst_n keeps both readies low during any reset cycle.
    assign w_grant     = rst_n && (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready  = w_grant && !w_win;
    assign req1_ready  = w_grant && w_win;
    assign w_rsp_ready = r_win ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_func   <= 2'b00;
            r_op1    <= 16'h0000;
            r_op2    <= 16'h0000;
            r_result <= 16'h0000;
            r_win    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_win   <= w_win;
                        r_func  <= w_win ? req1_func : req0_func;
                        r_op1   <= w_win ? req1_op1  : req0_op1;
                        r_op2   <= w_win ? req1_op2  : req0_op2;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= (r_func == c_FUNC_EQ) ? {15'b0, alu_eq} : alu_result;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Both requesters see the shared result register; only the winner's valid rises.
    assign rsp0_valid = (r_state == S_RESP) && !r_win;
    assign rsp1_valid = (r_state == S_RESP) && r_win;
    assign rsp0_data  = r_result;
    assign rsp1_data  = r_result;
    assign alu_func   = r_func;
    assign alu_op1    = r_op1;
    assign alu_op2    = r_op2;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed scoreboard bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0]  req0_func, req1_func, alu_func;
    logic [15:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] rsp0_data, rsp1_data, alu_op1, alu_op2, alu_result;
    logic        alu_eq;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_func  (req0_func),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_func  (req1_func),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .alu_func   (alu_func),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result),
        .alu_eq     (alu_eq)
    );

    // Shared ALU; the compare op returns a junk result so only alu_eq is meaningful.
    always_comb begin
        case (alu_func)
            2'b00:   alu_result = alu_op1 + alu_op2;
            2'b01:   alu_result = ~(alu_op1 & alu_op2);
            2'b10:   alu_result = alu_op1;
            default: alu_result = 16'h5A5A;
        endcase
        alu_eq = (alu_op1 == alu_op2);
    end

    typedef struct {
        logic        idx;
        logic [15:0] data;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          grants[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hold_cnt = 0;
    logic        seen = 1'b0;
    logic [15:0] last_data = 16'h0000;

    function automatic logic [15:0] model(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            2'b00:   return a + b;
            2'b01:   return ~(a & b);
            2'b10:   return a;
            default: return {15'b0, (a == b)};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score at the falling edge, then advance past the rising edge.
    task automatic cycle();
        exp_t        e;
        logic        w;
        logic [15:0] d;
        @(negedge clk);
        if (!rst_n) chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'h0);
        if (req0_ready || req1_ready) begin
            chk("ready_exclusive", {31'b0, req0_ready & req1_ready}, 32'h0);
            chk("ready_when_busy", sb.size(), 32'h0);
            e.idx  = req1_ready;
            e.data = req1_ready ? model(req1_func, req1_op1, req1_op2)
                                : model(req0_func, req0_op1, req0_op2);
            e.acc  = cyc;
            chk("ready_valid", {31'b0, req1_ready ? req1_valid : req0_valid}, 32'h1);
            sb.push_back(e);
            grants.push_back(req1_ready ? 1 : 0);
        end
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_exclusive", {31'b0, rsp0_valid & rsp1_valid}, 32'h0);
            if (sb.size() == 0) begin
                chk("rsp_pending", sb.size(), 32'h1);
            end else begin
                w = rsp1_valid;
                d = w ? rsp1_data : rsp0_data;
                chk("rsp_idx", {31'b0, w}, {31'b0, sb[0].idx});
                chk("rsp_data", {16'b0, d}, {16'b0, sb[0].data});
                if (!seen) chk("latency", cyc - sb[0].acc, 32'd2);
                seen = 1'b1;
                if (w ? rsp1_ready : rsp0_ready) begin
                    last_data = d;
                    void'(sb.pop_front());
                    seen = 1'b0;
                end else begin
                    hold_cnt++;
                end
            end
        end
        if (!rst_n) begin
            sb.delete();
            seen = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_empty(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) cycle();
        chk("drain_timeout", sb.size(), 32'h0);
    endtask

    task automatic do_req(input logic idx, input logic [1:0] f, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp, input string tag);
        if (idx) begin
            req1_func = f; req1_op1 = a; req1_op2 = b; req1_valid = 1'b1;
        end else begin
            req0_func = f; req0_op1 = a; req0_op2 = b; req0_valid = 1'b1;
        end
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_accepted"}, sb.size(), 32'h1);
        wait_empty(10);
        chk(tag, {16'b0, last_data}, {16'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_func = 2'b00; req0_op1 = 16'h0; req0_op2 = 16'h0;
        req1_valid = 1'b1; req1_func = 2'b00; req1_op1 = 16'h0; req1_op2 = 16'h0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk); #1;
        repeat (3) cycle();
        chk("reset_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
        chk("reset_rsp_data", {rsp1_data, rsp0_data}, 32'h0);
        chk("reset_alu_func", {30'b0, alu_func}, 32'h0);
        chk("reset_alu_ops", {alu_op1, alu_op2}, 32'h0);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cycle();

        do_req(1'b0, 2'b00, 16'h1234, 16'h0001, 16'h1235, "add_basic");
        do_req(1'b0, 2'b01, 16'hFF00, 16'h0F0F, 16'hF0FF, "nand");
        do_req(1'b1, 2'b11, 16'hBEEF, 16'hBEEF, 16'h0001, "eq_true");
        do_req(1'b1, 2'b11, 16'hBEEF, 16'hBEEE, 16'h0000, "eq_false");
        do_req(1'b1, 2'b10, 16'h3C3C, 16'hFFFF, 16'h3C3C, "pass");

        // Both requesters held valid: the last single grant went to requester 1.
        grants.delete();
        req0_func = 2'b00; req0_op1 = 16'h0001; req0_op2 = 16'h0001; req0_valid = 1'b1;
        req1_func = 2'b10; req1_op1 = 16'h7777; req1_op2 = 16'h0000; req1_valid = 1'b1;
        for (int i = 0; i < 40 && grants.size() < 4; i++) cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("contend_grants", grants.size(), 32'd4);
        wait_empty(10);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef ALU_ARB_RR_EN
            chk("contend_order", grants[i], i % 2);
`else
            chk("contend_order", grants[i], 32'd0);
`endif
        end

        // Response back-pressure with a competing requester waiting.
        grants.delete();
        req0_func = 2'b00; req0_op1 = 16'hFFFF; req0_op2 = 16'h0001; req0_valid = 1'b1;
        rsp0_ready = 1'b0;
        cycle();
        req0_valid = 1'b0;
        req1_func = 2'b10; req1_op1 = 16'h1111; req1_valid = 1'b1;
        hold_cnt = 0;
        cycle();
        repeat (5) cycle();
        chk("hold_cycles", hold_cnt, 32'd5);
        chk("hold_grants", grants.size(), 32'd1);
        rsp0_ready = 1'b1;
        cycle();
        chk("wrap_add", {16'b0, last_data}, 32'h0);
        cycle();
        req1_valid = 1'b0;
        chk("after_release_grant", grants.size() == 2 ? grants[1] : -1, 32'd1);
        wait_empty(10);
        chk("after_release_data", {16'b0, last_data}, 32'h1111);

        // Reset while executing drops the operation and the pointer.
        req0_func = 2'b00; req0_op1 = 16'h0001; req0_op2 = 16'h0002; req0_valid = 1'b1;
        cycle();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("no_rsp_after_reset", {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
            cycle();
        end
        grants.delete();
        req0_func = 2'b10; req0_op1 = 16'hA5A5; req0_op2 = 16'h0000; req0_valid = 1'b1;
        req1_func = 2'b00; req1_op1 = 16'h0002; req1_op2 = 16'h0003; req1_valid = 1'b1;
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("post_reset_grant", grants.size() == 1 ? grants[0] : -1, 32'd0);
        wait_empty(10);
        chk("post_reset_pass", {16'b0, last_data}, 32'hA5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
